// File: rtl/phy_lane_scheduler.sv
// phy_lane_scheduler
// Shares one byte-wide output path among four PHY lanes. Each lane feeds a
// small FIFO; a round-robin arbiter pops one non-empty lane per cycle into a
// registered valid/ready output stage. IDLE is driven when nothing is queued.
//
// Ports:
//   clk_4f                 clock, rising edge
//   rst                    synchronous reset, active high
//   in0..in3, valid_in0..3 lane bytes and their valids
//   ready_in0..3           lane FIFO can take a byte this cycle
//   out_ready              downstream accepts data_out this cycle
//   data_out, valid_out    scheduled byte (IDLE when valid_out is 0)
//   lane_out               source lane of data_out
//   overflow               sticky per-lane drop flags (bit N = lane N)
module phy_lane_scheduler #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] IDLE  = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       rst,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic       ready_in0,
  output logic       ready_in1,
  output logic       ready_in2,
  output logic       ready_in3,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic [3:0] overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    in_bus [4];
  logic [3:0]    valid_bus;
  logic [3:0]    ready;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [7:0]    mem    [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] count  [4];
  logic [1:0]    rr_ptr;
  logic [1:0]    gnt;
  logic          found;
  logic          load;

  assign in_bus[0] = in0;
  assign in_bus[1] = in1;
  assign in_bus[2] = in2;
  assign in_bus[3] = in3;
  assign valid_bus = {valid_in3, valid_in2, valid_in1, valid_in0};

  assign ready_in0 = ready[0];
  assign ready_in1 = ready[1];
  assign ready_in2 = ready[2];
  assign ready_in3 = ready[3];

  // Output stage may reload when empty or when its byte is being consumed.
  assign load = !valid_out || out_ready;

  // Readiness comes from registered counts only: a full FIFO refuses a push
  // even if it is popped on the same edge.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ready[n] = !rst && (count[n] < CW'(DEPTH));
      push[n]  = valid_bus[n] && ready[n];
    end
  end

  // Round-robin search starting at rr_ptr over pre-push FIFO occupancy.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    gnt   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && (count[idx] != '0)) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    for (int n = 0; n < 4; n++) begin
      pop[n] = load && found && (gnt == 2'(n));
    end
  end

  // Lane FIFO storage: written only on an accepted push, never reset.
  always_ff @(posedge clk_4f) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) begin
        mem[n][wr_ptr[n]] <= in_bus[n];
      end
    end
  end

  // Lane FIFO control and sticky drop flags.
  always_ff @(posedge clk_4f) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      overflow <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) begin
          wr_ptr[n] <= wr_ptr[n] + AW'(1);
        end
        if (pop[n]) begin
          rd_ptr[n] <= rd_ptr[n] + AW'(1);
        end
        case ({push[n], pop[n]})
          2'b10:   count[n] <= count[n] + CW'(1);
          2'b01:   count[n] <= count[n] - CW'(1);
          default: count[n] <= count[n];
        endcase
        if (valid_bus[n] && !ready[n]) begin
          overflow[n] <= 1'b1;
        end
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk_4f) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= IDLE;
      lane_out  <= 2'd0;
      rr_ptr    <= 2'd0;
    end else if (load) begin
      if (found) begin
        valid_out <= 1'b1;
        data_out  <= mem[gnt][rd_ptr[gnt]];
        lane_out  <= gnt;
        rr_ptr    <= gnt + 2'd1;
      end else begin
        valid_out <= 1'b0;
        data_out  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Testbench for phy_lane_scheduler: queue-based reference model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_phy_lane_scheduler;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [4];
  logic       vin [4];
  logic       out_ready = 1'b1;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [3:0] overflow;

  int ncmp = 0;
  int nmis = 0;

  always #5 clk_4f = ~clk_4f;

  phy_lane_scheduler #(.DEPTH(DEPTH), .IDLE(IDLE)) dut (
    .clk_4f(clk_4f), .rst(rst),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .valid_in0(vin[0]), .valid_in1(vin[1]), .valid_in2(vin[2]), .valid_in3(vin[3]),
    .ready_in0(rdy0), .ready_in1(rdy1), .ready_in2(rdy2), .ready_in3(rdy3),
    .out_ready(out_ready), .data_out(data_out), .valid_out(valid_out),
    .lane_out(lane_out), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q [4][$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = IDLE;
  int         m_lane = 0;
  int         m_ptr = 0;
  logic [3:0] m_ovf = 4'b0;
  bit         armed = 1'b0;

  always @(posedge clk_4f) begin
    bit room [4];
    bit found;
    int l;
    if (rst) begin
      for (int n = 0; n < 4; n++) q[n].delete();
      m_valid = 1'b0; m_data = IDLE; m_lane = 0; m_ptr = 0; m_ovf = 4'b0;
    end else begin
      for (int n = 0; n < 4; n++) room[n] = (q[n].size() < DEPTH);
      if (!m_valid || out_ready) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          l = (m_ptr + k) % 4;
          if (!found && q[l].size() > 0) begin
            found = 1'b1;
            m_data = q[l].pop_front();
            m_lane = l;
            m_valid = 1'b1;
            m_ptr = (l + 1) % 4;
          end
        end
        if (!found) begin
          m_valid = 1'b0;
          m_data = IDLE;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (vin[n]) begin
          if (room[n]) q[n].push_back(din[n]);
          else m_ovf[n] = 1'b1;
        end
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk_4f) begin
    logic [3:0] m_rdy;
    if (armed) begin
      for (int n = 0; n < 4; n++) m_rdy[n] = !rst && (q[n].size() < DEPTH);
      chk("model_valid_out", 32'(valid_out), 32'(m_valid));
      chk("model_data_out", 32'(data_out), 32'(m_data));
      chk("model_lane_out", 32'(lane_out), 32'(m_lane));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_ready_in", 32'({rdy3, rdy2, rdy1, rdy0}), 32'(m_rdy));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic clear_valids();
    for (int n = 0; n < 4; n++) vin[n] = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] l);
    chk({name, "_valid"}, 32'(valid_out), 32'(v));
    chk({name, "_data"}, 32'(data_out), 32'(d));
    if (v) chk({name, "_lane"}, 32'(lane_out), 32'(l));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_valids();
    out_ready = 1'b1;
    tick();
    expect_out("reset", 1'b0, IDLE, 2'd0);
    chk("reset_lane", 32'(lane_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_ready_low", 32'({rdy3, rdy2, rdy1, rdy0}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'({rdy3, rdy2, rdy1, rdy0}), 32'hF);
  endtask

  initial begin
    logic [7:0] b;
    int prev, c0, c2;
    for (int n = 0; n < 4; n++) begin din[n] = 8'h00; vin[n] = 1'b0; end
    tick();
    do_reset();

    // All four lanes at once, served in lane order.
    din[0] = 8'hAA; din[1] = 8'hCC; din[2] = 8'hEE; din[3] = 8'h11;
    for (int n = 0; n < 4; n++) vin[n] = 1'b1;
    tick();
    clear_valids();
    chk("t1_latency_valid", 32'(valid_out), 32'd0);
    tick(); expect_out("t1_b0", 1'b1, 8'hAA, 2'd0);
    tick(); expect_out("t1_b1", 1'b1, 8'hCC, 2'd1);
    tick(); expect_out("t1_b2", 1'b1, 8'hEE, 2'd2);
    tick(); expect_out("t1_b3", 1'b1, 8'h11, 2'd3);
    tick(); expect_out("t1_idle", 1'b0, IDLE, 2'd0);

    // Lanes 0 and 2 kept backlogged: strict alternation, push order kept.
    do_reset();
    prev = 2; c0 = 0; c2 = 0;
    b = 8'h00;
    for (int i = 0; i < 24; i++) begin
      vin[0] = rdy0; din[0] = (b[0] == 1'b0) ? 8'hBB : 8'hAA;
      vin[2] = rdy2; din[2] = (b[1] == 1'b0) ? 8'hFF : 8'hEE;
      if (rdy0) b[0] = ~b[0];
      if (rdy2) b[1] = ~b[1];
      tick();
      if (valid_out) begin
        chk("t2_alternate", 32'(lane_out), (prev == 0) ? 32'd2 : 32'd0);
        if (lane_out == 2'd0) begin
          chk("t2_lane0_order", 32'(data_out), (c0 % 2 == 0) ? 32'hBB : 32'hAA);
          c0++;
        end else begin
          chk("t2_lane2_order", 32'(data_out), (c2 % 2 == 0) ? 32'hFF : 32'hEE);
          c2++;
        end
        prev = int'(lane_out);
      end
    end
    clear_valids();
    for (int i = 0; i < 12; i++) tick();
    chk("t2_no_overflow", 32'(overflow), 32'd0);

    // Full backpressure: DEPTH+1 bytes absorbed, then drop.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      din[0] = 8'(k + 1); vin[0] = 1'b1;
      tick();
      if (k == 3) chk("t3_ready_before_full", 32'(rdy0), 32'd1);
      if (k == 4) chk("t3_ready_full", 32'(rdy0), 32'd0);
      if (k == 4) chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
    end
    chk("t3_overflow0", 32'(overflow), 32'h1);
    clear_valids();
    expect_out("t3_hold", 1'b1, 8'h01, 2'd0);
    tick(); expect_out("t3_hold2", 1'b1, 8'h01, 2'd0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick(); expect_out("t3_drain", 1'b1, 8'(k), 2'd0);
    end
    tick(); expect_out("t3_drained", 1'b0, IDLE, 2'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'h1);

    // Backpressure hold for three cycles, nothing popped meanwhile.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[1] = 8'h30 + 8'(k); vin[1] = 1'b1;
      tick();
    end
    clear_valids();
    for (int k = 0; k < 3; k++) begin
      tick(); expect_out("t4_hold", 1'b1, 8'h30, 2'd1);
    end
    out_ready = 1'b1;
    tick(); expect_out("t4_next1", 1'b1, 8'h31, 2'd1);
    tick(); expect_out("t4_next2", 1'b1, 8'h32, 2'd1);
    tick(); expect_out("t4_empty", 1'b0, IDLE, 2'd0);

    // Reset in the middle of traffic.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 4; n++) begin din[n] = 8'h40 + 8'(16 * n + k); vin[n] = 1'b1; end
      tick();
    end
    clear_valids();
    vin[1] = 1'b1; din[1] = 8'h77;
    tick();
    tick();
    chk("t5_overflow1", 32'(overflow), 32'h2);
    rst = 1'b1;
    tick();
    expect_out("t5_after_rst", 1'b0, IDLE, 2'd0);
    chk("t5_overflow_cleared", 32'(overflow), 32'd0);
    rst = 1'b0;
    clear_valids();
    out_ready = 1'b1;
    tick();
    chk("t5_no_stale", 32'(valid_out), 32'd0);
    for (int n = 0; n < 4; n++) begin din[n] = 8'h90 + 8'(n); vin[n] = 1'b1; end
    tick();
    clear_valids();
    tick(); expect_out("t5_first_grant", 1'b1, 8'h90, 2'd0);
    for (int i = 0; i < 4; i++) tick();

    // Lane 3 streamed through 3*DEPTH pointer wraps.
    do_reset();
    for (int k = 0; k < 3 * DEPTH; k++) begin
      din[3] = 8'hDD + 8'(8'h45 * k); vin[3] = 1'b1;
      tick();
      if (k > 0) expect_out("t6_wrap", 1'b1, 8'hDD + 8'(8'h45 * (k - 1)), 2'd3);
      chk("t6_ready", 32'(rdy3), 32'd1);
    end
    clear_valids();
    tick(); expect_out("t6_last", 1'b1, 8'hDD + 8'(8'h45 * (3 * DEPTH - 1)), 2'd3);
    tick(); expect_out("t6_idle", 1'b0, IDLE, 2'd0);
    chk("t6_no_overflow", 32'(overflow), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/phy_lane_scheduler.md
# phy_lane_scheduler

Round-robin scheduler that shares a single byte-wide output path among the four PHY input lanes (in0..in3 with per-lane valids). Each lane has a small FIFO; the scheduler picks one non-empty lane per cycle and presents its oldest byte on a registered valid/ready output toward the serializer. It inserts the IDLE symbol when no lane has data, and flags per-lane overflow. It sits between the lane sources and the parallel-to-serial stage of the PHY transmit path, in the clk_4f domain.

## Interface
- DEPTH, 4: entries per lane FIFO; power of two, at least 2.
- IDLE, 8'hBC: byte driven on data_out when valid_out is 0.

Ports:
- clk_4f  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active high.
- in0..in3  input  8 each  lane data bytes.
- valid_in0..valid_in3  input  1 each  lane byte valid.
- ready_in0..ready_in3  output  1 each  lane FIFO can accept a byte this cycle.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  8  scheduled byte, or IDLE.
- valid_out  output  1  data_out holds a lane byte.
- lane_out  output  2  source lane of data_out.
- overflow  output  4  sticky per-lane drop flags; bit N belongs to lane N.

## Operation
- Reset (rst high at an edge): all FIFOs empty, rr pointer = 0, valid_out=0, data_out=IDLE, lane_out=0, overflow=0. ready_inN is held at 0 while rst is high.
- ready_inN = !rst && (countN < DEPTH). The output uses registered counts; there is no pass-through, so a full FIFO rejects a push even when a pop happens in the same cycle.
- Push: at an edge with valid_inN && ready_inN, the byte enters FIFO N.
- Drop: at an edge with valid_inN && !ready_inN and rst low, the byte is discarded and overflow[N] sets. overflow[N] stays set until reset.
- Output register load condition: !valid_out || out_ready.
- When the load condition holds, the scheduler searches lanes in order ptr, ptr+1, ptr+2, ptr+3 (mod 4), using the FIFO state before this edge's pushes. It picks the first non-empty lane g:
  - pop FIFO g;
  - data_out = head byte, lane_out = g, valid_out = 1;
  - ptr = (g+1) mod 4.
- If the load condition holds but all FIFOs are empty: valid_out = 0, data_out = IDLE, lane_out keeps its value, ptr is unchanged.
- If the load condition is false (valid_out=1 and out_ready=0): data_out, lane_out and valid_out are held, and no FIFO pops.
- Transfer: valid_out && out_ready at an edge counts as the byte being consumed.
- FIFO pointers wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits wide. A simultaneous push and pop on a non-full FIFO leaves its count unchanged.

## Timing
- Latency: a byte pushed at edge t, into an empty scheduler with out_ready=1, appears on data_out/valid_out after edge t+1.
- Throughput: one byte per cycle while any FIFO is non-empty and out_ready=1.
- Fairness: each continuously backlogged lane is served at least once every 4 grants.
- Storage: under full backpressure, lane N accepts DEPTH+1 bytes in total (DEPTH in the FIFO, 1 in the output register) before ready_inN drops.
- Reset mid-operation: the state at the reset edge is discarded. The first push can happen at the first edge with rst low.
- All outputs are registered except ready_inN, which is decoded from registered counts and rst.

## Test plan
- Reset, then one cycle with in0..in3 = AA,CC,EE,11 and all valids high, out_ready=1 → on the next 4 cycles data_out/lane_out = AA/0, CC/1, EE/2, 11/3 with valid_out=1; after that valid_out=0 and data_out=BC.
- Lanes 0 and 2 fed continuously (lane 0 alternating BB/AA, lane 2 alternating FF/EE), lanes 1 and 3 idle, out_ready=1 → lane_out strictly alternates 0,2,0,2. Each lane's bytes come out in push order, and no overflow bit sets.
- out_ready=0, lane 0 driven valid with bytes 01,02,03,... → ready_in0 drops after 5 accepted bytes. The 6th byte sets overflow[0]. data_out holds 01 while valid_out=1. Raising out_ready then drains 01..05 in order.
- Backpressure hold: while valid_out=1, drop out_ready for 3 cycles → data_out and lane_out stay constant and the FIFO counts do not decrease.
- Reset mid-operation: with 3 bytes queued per lane and overflow[1] set, assert rst for one cycle → next cycle shows valid_out=0, data_out=BC, overflow=0. The next grant comes from lane 0.
- Wrap-around: push and pop lane 3 for 3×DEPTH bytes (DD,22,... pattern) → the output order is preserved across pointer wrap, and the count never exceeds DEPTH.
